id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  ID->EX boundary of the 5-stage pipeline, directly downstream of the register file.
//  Consumes GRF rd1/rd2 and bypasses them with MEM/WB results.
//  Detects load-use hazards and inserts bubbles.
//  Latches the resolved operands, PC, immediate and control into the ID/EX pipeline register, with stall/flush.
// PARAMETERS
//  CTRL_W   16   width of the opaque control bundle carried ID->EX
// PORTS
//  clk        in   1       clock; all state updates on posedge
//  clr_n      in   1       synchronous, active-low reset (sampled on posedge clk)
//  stall      in   1       downstream freeze: hold ID/EX contents
//  flush      in   1       kill the instruction entering EX (branch/jump resolve)
//  id_pc      in   32      PC of instruction in ID
//  id_rs      in   5       GRF a1 index
//  id_rt      in   5       GRF a2 index
//  id_use_rs  in   1       ID instruction reads rs
//  id_use_rt  in   1       ID instruction reads rt
//  id_dst     in   5       destination register of ID instruction
//  id_is_load in   1       ID instruction is a load
//  id_rd1     in   32      GRF rd1
//  id_rd2     in   32      GRF rd2
//  id_imm     in   32      extended immediate
//  id_ctrl    in   CTRL_W  control bundle
//  mem_we     in   1       MEM-stage write enable
//  mem_a3     in   5       MEM-stage write index
//  mem_wd     in   32      MEM-stage write data
//  wb_we      in   1       WB-stage write enable (same signals driving GRF we/a3/wd)
//  wb_a3      in   5       WB-stage write index
//  wb_wd      in   32      WB-stage write data
//  stall_req  out  1       combinational: load-use hazard, hold PC and IF/ID
//  ex_valid   out  1       EX slot holds a real instruction
//  ex_pc      out  32      registered id_pc
//  ex_rs      out  5       registered id_rs
//  ex_rt      out  5       registered id_rt
//  ex_dst     out  5       registered id_dst
//  ex_is_load out  1       registered id_is_load
//  ex_v1      out  32      registered forwarded operand 1
//  ex_v2      out  32      registered forwarded operand 2
//  ex_imm     out  32      registered id_imm
//  ex_ctrl    out  CTRL_W  registered id_ctrl
//  bubble_cnt out  32      count of inserted bubbles, saturates at 32'hFFFFFFFF
// BEHAVIOUR
//  - Reset (clr_n=0 at posedge): all ex_* outputs = 0, ex_valid = 0, bubble_cnt = 0.
//  - Forwarding (combinational, per operand, rs shown; rt identical):
//    - if mem_we && mem_a3!=0 && mem_a3==id_rs: v1 = mem_wd;
//    - else if wb_we && wb_a3!=0 && wb_a3==id_rs: v1 = wb_wd;
//    - else v1 = id_rd1. MEM has priority over WB; index 0 is never forwarded.
//    - The WB bypass is mandatory: GRF updates only at the edge.
//  - Hazard (combinational):
//    - stall_req = ex_valid && ex_is_load && ex_dst!=0 && ((id_use_rs && ex_dst==id_rs) || (id_use_rt && ex_dst==id_rt)).
//  - Register update at posedge, first match wins:
//    1. clr_n=0: reset as above.
//    2. flush: load a bubble: ex_valid=0, ex_ctrl=0, ex_is_load=0, ex_dst=0; other fields don't-care, driven 0.
//    3. stall: hold every ex_* field, including ex_v1/ex_v2.
//    4. stall_req: load a bubble (as in 2); bubble_cnt += 1, saturating.
//    5. Otherwise: ex_valid=1; all fields load from ID; ex_v1/ex_v2 load the forwarded values.
//  - Latency: 1 cycle ID->EX; stall_req resolves after exactly one bubble, since the load moves to MEM and is forwarded from mem_wd.
//  - Flush during a stall_req does not increment bubble_cnt. A flush that arrives with stall still kills the slot.
//  - A stall while stall_req is set holds the register; the hazard is re-evaluated next cycle.
// TESTING
//  1. Reset: clr_n=0 for 2 cycles with random inputs -> all ex_* = 0, bubble_cnt = 0.
//  2. MEM vs WB priority: id_rs=5, mem_a3=5 (wd 32'h11), wb_a3=5 (wd 32'h22), id_rd1=32'h33 -> ex_v1 = 32'h11.
//     Drop mem_we -> ex_v1 = 32'h22.
//  3. $0 guard: id_rt=0, mem_a3=0, mem_we=1, mem_wd=32'hDEAD, id_rd2=0 -> ex_v2 = 0.
//  4. Load-use: lw to $8 in EX, then ID addu using $8 as rs -> stall_req=1 for one cycle.
//     ex_valid=0 next; bubble_cnt=1; following cycle ex_v1 = mem_wd.
//  5. Flush vs stall: assert flush and stall together with a valid ID instruction -> ex_valid=0 after the edge.
//     stall alone -> ex_* unchanged for 3 cycles.
//  6. Counter saturation: force bubble_cnt to 32'hFFFFFFFE, trigger 3 load-use bubbles -> bubble_cnt = 32'hFFFFFFFF.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand bypass and load-use bubble insertion.
// Bubbles are slots with ex_valid=0. Every field is zero in a bubble, so a bubble never looks like a load.
module id_ex_operand_stage #(
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              stall,
    input  logic              flush,
    input  logic [31:0]       id_pc,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [4:0]        id_dst,
    input  logic              id_is_load,
    input  logic [31:0]       id_rd1,
    input  logic [31:0]       id_rd2,
    input  logic [31:0]       id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              mem_we,
    input  logic [4:0]        mem_a3,
    input  logic [31:0]       mem_wd,
    input  logic              wb_we,
    input  logic [4:0]        wb_a3,
    input  logic [31:0]       wb_wd,
    output logic              stall_req,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_dst,
    output logic              ex_is_load,
    output logic [31:0]       ex_v1,
    output logic [31:0]       ex_v2,
    output logic [31:0]       ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [31:0]       bubble_cnt
);

    logic              valid_q,   valid_d;
    logic [31:0]       pc_q,      pc_d;
    logic [4:0]        rs_q,      rs_d;
    logic [4:0]        rt_q,      rt_d;
    logic [4:0]        dst_q,     dst_d;
    logic              is_load_q, is_load_d;
    logic [31:0]       v1_q,      v1_d;
    logic [31:0]       v2_q,      v2_d;
    logic [31:0]       imm_q,     imm_d;
    logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
    logic [31:0]       cnt_q,     cnt_d;

    logic [31:0] fwd_v1;
    logic [31:0] fwd_v2;

    // The WB bypass is required because the GRF only writes at the clock edge. MEM is newer, so it wins over WB.
    always_comb begin
        fwd_v1 = id_rd1;
        if (mem_we && mem_a3 != 5'd0 && mem_a3 == id_rs)
            fwd_v1 = mem_wd;
        else if (wb_we && wb_a3 != 5'd0 && wb_a3 == id_rs)
            fwd_v1 = wb_wd;

        fwd_v2 = id_rd2;
        if (mem_we && mem_a3 != 5'd0 && mem_a3 == id_rt)
            fwd_v2 = mem_wd;
        else if (wb_we && wb_a3 != 5'd0 && wb_a3 == id_rt)
            fwd_v2 = wb_wd;
    end

    assign stall_req = valid_q && is_load_q && (dst_q != 5'd0) &&
                       ((id_use_rs && dst_q == id_rs) || (id_use_rt && dst_q == id_rt));

    // Priority order: flush, then stall, then a hazard bubble, then a normal load from ID.
    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        dst_d     = dst_q;
        is_load_d = is_load_q;
        v1_d      = v1_q;
        v2_d      = v2_q;
        imm_d     = imm_q;
        ctrl_d    = ctrl_q;
        cnt_d     = cnt_q;

        if (flush || (!stall && stall_req)) begin
            valid_d   = 1'b0;
            pc_d      = '0;
            rs_d      = '0;
            rt_d      = '0;
            dst_d     = '0;
            is_load_d = 1'b0;
            v1_d      = '0;
            v2_d      = '0;
            imm_d     = '0;
            ctrl_d    = '0;
            if (!flush && cnt_q != 32'hFFFF_FFFF)
                cnt_d = cnt_q + 32'd1;
        end else if (!stall) begin
            valid_d   = 1'b1;
            pc_d      = id_pc;
            rs_d      = id_rs;
            rt_d      = id_rt;
            dst_d     = id_dst;
            is_load_d = id_is_load;
            v1_d      = fwd_v1;
            v2_d      = fwd_v2;
            imm_d     = id_imm;
            ctrl_d    = id_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            dst_q     <= '0;
            is_load_q <= 1'b0;
            v1_q      <= '0;
            v2_q      <= '0;
            imm_q     <= '0;
            ctrl_q    <= '0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            dst_q     <= dst_d;
            is_load_q <= is_load_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            imm_q     <= imm_d;
            ctrl_q    <= ctrl_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_pc      = pc_q;
    assign ex_rs      = rs_q;
    assign ex_rt      = rt_q;
    assign ex_dst     = dst_q;
    assign ex_is_load = is_load_q;
    assign ex_v1      = v1_q;
    assign ex_v2      = v2_q;
    assign ex_imm     = imm_q;
    assign ex_ctrl    = ctrl_q;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: table-driven forwarding vectors plus hand sequences for hazards, stall/flush and saturation.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        stall, flush;
    logic [31:0] id_pc;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic        id_use_rs, id_use_rt, id_is_load;
    logic [31:0] id_rd1, id_rd2, id_imm;
    logic [15:0] id_ctrl;
    logic        mem_we, wb_we;
    logic [4:0]  mem_a3, wb_a3;
    logic [31:0] mem_wd, wb_wd;
    logic        stall_req, ex_valid, ex_is_load;
    logic [31:0] ex_pc, ex_v1, ex_v2, ex_imm, bubble_cnt;
    logic [4:0]  ex_rs, ex_rt, ex_dst;
    logic [15:0] ex_ctrl;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage #(.CTRL_W(16)) dut (
        .clk(clk), .clr_n(clr_n), .stall(stall), .flush(flush),
        .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
        .id_is_load(id_is_load), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_imm(id_imm), .id_ctrl(id_ctrl),
        .mem_we(mem_we), .mem_a3(mem_a3), .mem_wd(mem_wd),
        .wb_we(wb_we), .wb_a3(wb_a3), .wb_wd(wb_wd),
        .stall_req(stall_req), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst), .ex_is_load(ex_is_load),
        .ex_v1(ex_v1), .ex_v2(ex_v2), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
        .bubble_cnt(bubble_cnt)
    );

    typedef struct {
        logic [4:0]  rs, rt;
        logic [31:0] rd1, rd2;
        logic        mem_we;
        logic [4:0]  mem_a3;
        logic [31:0] mem_wd;
        logic        wb_we;
        logic [4:0]  wb_a3;
        logic [31:0] wb_wd;
        logic [31:0] exp_v1, exp_v2;
    } vec_t;

    vec_t vecs [7];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic use_rs, input logic use_rt, input logic [4:0] dst,
                                 input logic is_load, input logic [31:0] rd1, input logic [31:0] rd2);
        id_pc = pc; id_rs = rs; id_rt = rt; id_use_rs = use_rs; id_use_rt = use_rt;
        id_dst = dst; id_is_load = is_load; id_rd1 = rd1; id_rd2 = rd2;
        id_imm = pc ^ 32'h0000_00F0; id_ctrl = pc[15:0] | 16'h8000;
    endtask

    task automatic quietBypass();
        mem_we = 1'b0; mem_a3 = 5'd0; mem_wd = 32'h0;
        wb_we = 1'b0; wb_a3 = 5'd0; wb_wd = 32'h0;
        stall = 1'b0; flush = 1'b0;
    endtask

    initial begin
        vecs[0] = '{5'd5, 5'd6, 32'h33, 32'h44, 1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22, 32'h11, 32'h44};
        vecs[1] = '{5'd5, 5'd6, 32'h33, 32'h44, 1'b0, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22, 32'h22, 32'h44};
        vecs[2] = '{5'd3, 5'd0, 32'h77, 32'h0,  1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'h0, 32'h77, 32'h0};
        vecs[3] = '{5'd1, 5'd7, 32'h10, 32'h20, 1'b0, 5'd7, 32'hBAD, 1'b1, 5'd7, 32'h55, 32'h10, 32'h55};
        vecs[4] = '{5'd2, 5'd0, 32'h66, 32'h0,  1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h99, 32'h66, 32'h0};
        vecs[5] = '{5'd9, 5'd9, 32'h1,  32'h2,  1'b1, 5'd9, 32'hAA, 1'b1, 5'd9, 32'hBB, 32'hAA, 32'hAA};
        vecs[6] = '{5'd5, 5'd6, 32'h123, 32'h456, 1'b1, 5'd4, 32'hEE, 1'b1, 5'd3, 32'hFF, 32'h123, 32'h456};

        // Reset with random inputs on every port.
        clr_n = 1'b0;
        stall = 1'($urandom); flush = 1'($urandom);
        mem_we = 1'($urandom); mem_a3 = 5'($urandom); mem_wd = $urandom;
        wb_we = 1'($urandom); wb_a3 = 5'($urandom); wb_wd = $urandom;
        applyStimulus($urandom, 5'($urandom), 5'($urandom), 1'b1, 1'b1, 5'($urandom), 1'b1, $urandom, $urandom);
        step();
        step();
        checkOutput("rst_valid", 32'(ex_valid), 32'h0);
        checkOutput("rst_pc", ex_pc, 32'h0);
        checkOutput("rst_v1", ex_v1, 32'h0);
        checkOutput("rst_v2", ex_v2, 32'h0);
        checkOutput("rst_ctrl", 32'(ex_ctrl), 32'h0);
        checkOutput("rst_dst", 32'(ex_dst), 32'h0);
        checkOutput("rst_load", 32'(ex_is_load), 32'h0);
        checkOutput("rst_cnt", bubble_cnt, 32'h0);
        clr_n = 1'b1;
        quietBypass();

        for (int i = 0; i < 7; i++) begin
            mem_we = vecs[i].mem_we; mem_a3 = vecs[i].mem_a3; mem_wd = vecs[i].mem_wd;
            wb_we = vecs[i].wb_we; wb_a3 = vecs[i].wb_a3; wb_wd = vecs[i].wb_wd;
            applyStimulus(32'h1000 + 32'(i) * 4, vecs[i].rs, vecs[i].rt, 1'b1, 1'b1,
                          5'(i + 10), 1'b0, vecs[i].rd1, vecs[i].rd2);
            step();
            checkOutput($sformatf("vec%0d_v1", i), ex_v1, vecs[i].exp_v1);
            checkOutput($sformatf("vec%0d_v2", i), ex_v2, vecs[i].exp_v2);
            checkOutput($sformatf("vec%0d_pc", i), ex_pc, 32'h1000 + 32'(i) * 4);
            checkOutput($sformatf("vec%0d_imm", i), ex_imm, (32'h1000 + 32'(i) * 4) ^ 32'hF0);
            checkOutput($sformatf("vec%0d_valid", i), 32'(ex_valid), 32'h1);
            checkOutput($sformatf("vec%0d_dst", i), 32'(ex_dst), 32'(i + 10));
        end
        quietBypass();

        // Load-use: lw $8 enters EX, then addu reading $8 must wait exactly one bubble.
        applyStimulus(32'h2000, 5'd1, 5'd2, 1'b1, 1'b0, 5'd8, 1'b1, 32'h0, 32'h0);
        step();
        checkOutput("lw_is_load", 32'(ex_is_load), 32'h1);
        applyStimulus(32'h2004, 5'd8, 5'd3, 1'b1, 1'b1, 5'd9, 1'b0, 32'h0BAD, 32'h3);
        #1;
        checkOutput("lu_stall_req", 32'(stall_req), 32'h1);
        step();
        checkOutput("lu_bubble_valid", 32'(ex_valid), 32'h0);
        checkOutput("lu_bubble_cnt", bubble_cnt, 32'h1);
        checkOutput("lu_req_clear", 32'(stall_req), 32'h0);
        mem_we = 1'b1; mem_a3 = 5'd8; mem_wd = 32'hCAFE;
        step();
        checkOutput("lu_fwd_v1", ex_v1, 32'hCAFE);
        checkOutput("lu_valid", 32'(ex_valid), 32'h1);
        quietBypass();

        // Flush together with stall still kills the slot.
        applyStimulus(32'h3000, 5'd4, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 32'h1, 32'h2);
        flush = 1'b1; stall = 1'b1;
        step();
        checkOutput("fs_valid", 32'(ex_valid), 32'h0);
        checkOutput("fs_ctrl", 32'(ex_ctrl), 32'h0);
        checkOutput("fs_dst", 32'(ex_dst), 32'h0);
        quietBypass();
        applyStimulus(32'h200, 5'd2, 5'd3, 1'b1, 1'b1, 5'd4, 1'b0, 32'h1234, 32'h5678);
        step();
        checkOutput("pre_stall_pc", ex_pc, 32'h200);
        stall = 1'b1;
        applyStimulus(32'h300, 5'd7, 5'd7, 1'b1, 1'b1, 5'd11, 1'b1, 32'h9999, 32'h8888);
        for (int c = 0; c < 3; c++) begin
            step();
            checkOutput($sformatf("hold%0d_pc", c), ex_pc, 32'h200);
            checkOutput($sformatf("hold%0d_v1", c), ex_v1, 32'h1234);
            checkOutput($sformatf("hold%0d_v2", c), ex_v2, 32'h5678);
            checkOutput($sformatf("hold%0d_valid", c), 32'(ex_valid), 32'h1);
        end
        stall = 1'b0;

        // Flush during a load-use hazard does not count a bubble.
        applyStimulus(32'h4000, 5'd1, 5'd2, 1'b1, 1'b0, 5'd8, 1'b1, 32'h0, 32'h0);
        step();
        applyStimulus(32'h4004, 5'd8, 5'd3, 1'b1, 1'b1, 5'd9, 1'b0, 32'h0, 32'h0);
        flush = 1'b1;
        #1;
        checkOutput("fl_stall_req", 32'(stall_req), 32'h1);
        step();
        checkOutput("fl_cnt", bubble_cnt, 32'h1);
        checkOutput("fl_valid", 32'(ex_valid), 32'h0);
        flush = 1'b0;

        // Saturation: preload the counter just below its ceiling, then insert three bubbles.
        dut.cnt_q = 32'hFFFF_FFFE;
        for (int b = 0; b < 3; b++) begin
            applyStimulus(32'h5000, 5'd1, 5'd2, 1'b1, 1'b0, 5'd8, 1'b1, 32'h0, 32'h0);
            step();
            applyStimulus(32'h5004, 5'd8, 5'd3, 1'b1, 1'b1, 5'd9, 1'b0, 32'h0, 32'h0);
            step();
            checkOutput($sformatf("sat%0d_cnt", b), bubble_cnt, 32'hFFFF_FFFF);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
